// File: rtl/traffic_phase_if.sv
// Signal bundle between the traffic phase sequencer and its phase timer / lamp driver.
// The slave side is the sequencer; the master side drives timer pulses and congestion flags.
interface traffic_phase_if;
  logic        expired;
  logic [3:0]  congestion;
  logic [3:0]  state;
  logic [11:0] lights;
  logic        cycle_done;
  logic        fault;

  modport master (
    output expired,
    output congestion,
    input  state,
    input  lights,
    input  cycle_done,
    input  fault
  );

  modport slave (
    input  expired,
    input  congestion,
    output state,
    output lights,
    output cycle_done,
    output fault
  );
endinterface

// File: rtl/traffic_phase_fsm.sv
// Four-direction traffic phase sequencer: ALL_RED -> green (primary or extended) -> yellow,
// rotating through directions, with a dwell watchdog and illegal-state recovery.
module traffic_phase_fsm #(
  parameter int WDOG_LIMIT = 40
) (
  input  logic            clk,
  input  logic            rst,
  traffic_phase_if.slave  bus
);

  typedef enum logic [3:0] {
    S_ALL_RED = 4'd0,
    S_G0      = 4'd1,
    S_X0      = 4'd2,
    S_Y0      = 4'd3,
    S_G1      = 4'd4,
    S_X1      = 4'd5,
    S_Y1      = 4'd6,
    S_G2      = 4'd7,
    S_X2      = 4'd8,
    S_Y2      = 4'd9,
    S_G3      = 4'd10,
    S_X3      = 4'd11,
    S_Y3      = 4'd12
  } state_t;

  localparam logic [5:0]  DWELL_MAX = 6'd63;
  localparam logic [5:0]  WDOG_CNT  = 6'(WDOG_LIMIT);
  localparam logic [11:0] ALL_RED_LAMPS = 12'b100_100_100_100;

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  dir_q;
  logic [1:0]  dir_d;
  logic [5:0]  dwell_q;
  logic        fault_q;
  logic        fault_d;
  logic        cycle_done_q;
  logic        cycle_done_d;
  logic [11:0] lights_q;
  logic [3:0]  green_base;
  logic        legal;
  logic        wdog_trip;

  // Each case arm touches exactly one direction's lamp group, so at most one
  // direction can ever show green or yellow.
  function automatic logic [11:0] lights_of(input state_t s);
    logic [11:0] l;
    l = ALL_RED_LAMPS;
    case (s)
      S_G0, S_X0: l[2:0]   = 3'b001;
      S_Y0:       l[2:0]   = 3'b010;
      S_G1, S_X1: l[5:3]   = 3'b001;
      S_Y1:       l[5:3]   = 3'b010;
      S_G2, S_X2: l[8:6]   = 3'b001;
      S_Y2:       l[8:6]   = 3'b010;
      S_G3, S_X3: l[11:9]  = 3'b001;
      S_Y3:       l[11:9]  = 3'b010;
      default:    l        = ALL_RED_LAMPS;
    endcase
    return l;
  endfunction

  function automatic logic [5:0] dwell_next(input logic [5:0] d);
    return (d == DWELL_MAX) ? DWELL_MAX : d + 6'd1;
  endfunction

  // Primary green code for the direction being served next: 3*dir + 1.
  assign green_base = ({2'b00, dir_q} << 1) + {2'b00, dir_q} + 4'd1;
  assign legal      = (state_q <= S_Y3);
  assign wdog_trip  = (dwell_q == WDOG_CNT) && !bus.expired;

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    fault_d      = fault_q;
    cycle_done_d = 1'b0;
    if (!legal) begin
      state_d = S_ALL_RED;
      fault_d = 1'b1;
    end else if (bus.expired) begin
      // Congestion only matters on the ALL_RED -> green edge.
      case (state_q)
        S_ALL_RED: state_d = bus.congestion[dir_q] ? state_t'(green_base + 4'd1)
                                                   : state_t'(green_base);
        S_G0, S_X0: state_d = S_Y0;
        S_G1, S_X1: state_d = S_Y1;
        S_G2, S_X2: state_d = S_Y2;
        S_G3, S_X3: state_d = S_Y3;
        S_Y0, S_Y1, S_Y2, S_Y3: begin
          state_d      = S_ALL_RED;
          dir_d        = dir_q + 2'd1;
          cycle_done_d = (state_q == S_Y3);
        end
        default: state_d = S_ALL_RED;
      endcase
    end else if (wdog_trip) begin
      // Recovery keeps dir so the interrupted direction gets served again.
      state_d = S_ALL_RED;
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_ALL_RED;
      dir_q        <= 2'd0;
      dwell_q      <= 6'd0;
      fault_q      <= 1'b0;
      cycle_done_q <= 1'b0;
      lights_q     <= ALL_RED_LAMPS;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      fault_q      <= fault_d;
      cycle_done_q <= cycle_done_d;
      lights_q     <= lights_of(state_d);
      dwell_q      <= (state_d != state_q) ? 6'd0 : dwell_next(dwell_q);
    end
  end

  assign bus.state      = state_q;
  assign bus.lights     = lights_q;
  assign bus.cycle_done = cycle_done_q;
  assign bus.fault      = fault_q;

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// Bench for traffic_phase_fsm: vector table, hand-written corner sequences and
// randomized traffic checked against a phase-level behavioural model.
module tb_traffic_phase_fsm;

  localparam int WDOG_LIMIT = 40;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  traffic_phase_if bus ();

  traffic_phase_fsm #(.WDOG_LIMIT(WDOG_LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: phase kind 0=all red, 1=primary green, 2=extended green, 3=yellow.
  int m_phase;
  int m_srv;
  int m_dir;
  int m_dwell;
  int m_fault;
  int m_cd;

  function automatic int m_code();
    if (m_phase == 0) return 0;
    return 3 * m_srv + m_phase;
  endfunction

  function automatic logic [11:0] m_lights();
    logic [11:0] l;
    for (int d = 0; d < 4; d++) begin
      if (m_phase != 0 && d == m_srv)
        l[3*d +: 3] = (m_phase == 3) ? 3'b010 : 3'b001;
      else
        l[3*d +: 3] = 3'b100;
    end
    return l;
  endfunction

  task automatic model_step(input logic r, input logic e, input logic [3:0] c);
    int old_code;
    if (r) begin
      m_phase = 0; m_srv = 0; m_dir = 0; m_dwell = 0; m_fault = 0; m_cd = 0;
      return;
    end
    old_code = m_code();
    m_cd = 0;
    if (e) begin
      if (m_phase == 0) begin
        m_srv   = m_dir;
        m_phase = c[m_dir] ? 2 : 1;
      end else if (m_phase == 3) begin
        m_cd    = (m_dir == 3) ? 1 : 0;
        m_dir   = (m_dir + 1) % 4;
        m_phase = 0;
      end else begin
        m_phase = 3;
      end
    end else if (m_dwell == WDOG_LIMIT) begin
      m_phase = 0;
      m_fault = 1;
    end
    if (m_code() != old_code) m_dwell = 0;
    else if (m_dwell < 63) m_dwell++;
  endtask

  task automatic tick(input logic r, input logic e, input logic [3:0] c);
    @(negedge clk);
    rst            = r;
    bus.expired    = e;
    bus.congestion = c;
    @(posedge clk);
    model_step(r, e, c);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] st, input logic [11:0] li,
                         input logic cd, input logic fl);
    chk({tag, ".state"},      32'(bus.state),      32'(st));
    chk({tag, ".lights"},     32'(bus.lights),     32'(li));
    chk({tag, ".cycle_done"}, 32'(bus.cycle_done), 32'(cd));
    chk({tag, ".fault"},      32'(bus.fault),      32'(fl));
  endtask

  task automatic chk_model(input string tag);
    chk_all(tag, 4'(m_code()), m_lights(), 1'(m_cd), 1'(m_fault));
  endtask

  typedef struct {
    logic        r;
    logic        e;
    logic [3:0]  c;
    logic [3:0]  st;
    logic [11:0] li;
    logic        cd;
    logic        fl;
  } vec_t;

  function automatic vec_t mkv(input logic r, input logic e, input logic [3:0] c,
                               input logic [3:0] st, input logic [11:0] li, input logic cd);
    vec_t v;
    v.r = r; v.e = e; v.c = c; v.st = st; v.li = li; v.cd = cd; v.fl = 1'b0;
    return v;
  endfunction

  localparam logic [11:0] RED = 12'b100_100_100_100;

  vec_t tbl[15];

  initial begin
    checks   = 0;
    failures = 0;
    rst            = 1'b1;
    bus.expired    = 1'b0;
    bus.congestion = 4'b0000;

    // Full rotation with direction 1 congested; row 2 flips congestion mid-green.
    tbl[0]  = mkv(1'b1, 1'b0, 4'b0010, 4'd0,  RED,              1'b0);
    tbl[1]  = mkv(1'b0, 1'b1, 4'b0010, 4'd1,  12'b100_100_100_001, 1'b0);
    tbl[2]  = mkv(1'b0, 1'b0, 4'b1111, 4'd1,  12'b100_100_100_001, 1'b0);
    tbl[3]  = mkv(1'b0, 1'b1, 4'b1111, 4'd3,  12'b100_100_100_010, 1'b0);
    tbl[4]  = mkv(1'b0, 1'b1, 4'b0010, 4'd0,  RED,              1'b0);
    tbl[5]  = mkv(1'b0, 1'b1, 4'b0010, 4'd5,  12'b100_100_001_100, 1'b0);
    tbl[6]  = mkv(1'b0, 1'b1, 4'b0010, 4'd6,  12'b100_100_010_100, 1'b0);
    tbl[7]  = mkv(1'b0, 1'b1, 4'b0010, 4'd0,  RED,              1'b0);
    tbl[8]  = mkv(1'b0, 1'b1, 4'b0010, 4'd7,  12'b100_001_100_100, 1'b0);
    tbl[9]  = mkv(1'b0, 1'b1, 4'b0010, 4'd9,  12'b100_010_100_100, 1'b0);
    tbl[10] = mkv(1'b0, 1'b1, 4'b0010, 4'd0,  RED,              1'b0);
    tbl[11] = mkv(1'b0, 1'b1, 4'b0010, 4'd10, 12'b001_100_100_100, 1'b0);
    tbl[12] = mkv(1'b0, 1'b1, 4'b0010, 4'd12, 12'b010_100_100_100, 1'b0);
    tbl[13] = mkv(1'b0, 1'b1, 4'b0010, 4'd0,  RED,              1'b1);
    tbl[14] = mkv(1'b0, 1'b0, 4'b0010, 4'd0,  RED,              1'b0);

    for (int i = 0; i < 15; i++) begin
      tick(tbl[i].r, tbl[i].e, tbl[i].c);
      chk_all($sformatf("tbl%0d", i), tbl[i].st, tbl[i].li, tbl[i].cd, tbl[i].fl);
    end

    // First green after reset with no congestion.
    tick(1'b1, 1'b0, 4'b0000);
    tick(1'b0, 1'b1, 4'b0000);
    chk_all("first_green", 4'd1, 12'b100_100_100_001, 1'b0, 1'b0);

    // Watchdog trips on the edge after dwell reaches the limit; dir is kept.
    tick(1'b1, 1'b0, 4'b0000);
    tick(1'b0, 1'b1, 4'b0000);
    for (int i = 0; i < WDOG_LIMIT; i++) tick(1'b0, 1'b0, 4'b0000);
    chk_all("wdog_pre", 4'd1, 12'b100_100_100_001, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 4'b0000);
    chk_all("wdog_trip", 4'd0, RED, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 4'b0000);
    chk_all("wdog_reserve", 4'd1, 12'b100_100_100_001, 1'b0, 1'b1);

    // Expired coinciding with the watchdog condition wins, fault untouched.
    tick(1'b1, 1'b0, 4'b0000);
    tick(1'b0, 1'b1, 4'b0000);
    for (int i = 0; i < WDOG_LIMIT; i++) tick(1'b0, 1'b0, 4'b0000);
    tick(1'b0, 1'b1, 4'b0000);
    chk_all("wdog_vs_expired", 4'd3, 12'b100_100_100_010, 1'b0, 1'b0);

    // Reset mid-yellow with fault set clears everything.
    tick(1'b1, 1'b0, 4'b0000);
    tick(1'b0, 1'b1, 4'b0000);
    for (int i = 0; i <= WDOG_LIMIT; i++) tick(1'b0, 1'b0, 4'b0000);
    tick(1'b0, 1'b1, 4'b0000);
    tick(1'b0, 1'b1, 4'b0000);
    tick(1'b0, 1'b1, 4'b0000);
    tick(1'b0, 1'b1, 4'b0010);
    tick(1'b0, 1'b1, 4'b0000);
    chk_all("pre_rst_yellow", 4'd6, 12'b100_100_010_100, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 4'b0000);
    chk_all("rst_mid_yellow", 4'd0, RED, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 4'b0000);
    chk_all("post_rst_green", 4'd1, 12'b100_100_100_001, 1'b0, 1'b0);

    // Randomized traffic in blocks of varying timer activity so the watchdog gets exercised.
    begin
      int mode;
      logic e;
      logic r;
      mode = 0;
      for (int n = 0; n < 4000; n++) begin
        if (n % 256 == 0) mode = $urandom_range(0, 2);
        case (mode)
          0:       e = 1'($urandom_range(0, 1));
          1:       e = ($urandom_range(0, 7) == 0);
          default: e = ($urandom_range(0, 99) == 0);
        endcase
        r = ($urandom_range(0, 999) == 0);
        tick(r, e, 4'($urandom_range(0, 15)));
        chk_model($sformatf("rnd%0d", n));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_phase_fsm.md
TRAFFIC_PHASE_FSM -- requirements
Module: traffic_phase_fsm

Interface
REQ-001 Parameter WDOG_LIMIT, default 40, is the dwell-cycle count in one state without `expired` that triggers watchdog recovery; legal range 34..63.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 expired  input  1  single-cycle pulse from the phase timer meaning the current state's duration has elapsed.
REQ-005 congestion  input  4  per-direction congestion flags; bit d corresponds to direction d (0..3).
REQ-006 state  output  4  registered current phase code; drives the phase timer's state input.
REQ-007 lights  output  12  registered lamp drive; lights[3d+2:3d] = {red, yellow, green} for direction d.
REQ-008 cycle_done  output  1  registered one-cycle pulse marking completion of a full four-direction rotation.
REQ-009 fault  output  1  sticky watchdog or illegal-state flag.

Function
REQ-010 The FSM SHALL use this state encoding:
- 0000 ALL_RED
- direction d = 0..3 uses base b = 3d+1; b = primary green, b+1 = extended green, b+2 = yellow
- codes 1101..1111 are illegal
REQ-011 A 2-bit direction pointer dir SHALL select the direction served next.
REQ-012 ALL_RED with expired=1 SHALL transition to green for dir:
- extended green (b+1) if congestion[dir]=1 in that cycle
- primary green (b) otherwise
REQ-013 Congestion SHALL be sampled only on the ALL_RED->green edge; changes during green or yellow are ignored.
REQ-014 Either green state (b or b+1) with expired=1 SHALL transition to yellow (b+2) of the same direction.
REQ-015 Yellow with expired=1 SHALL transition to ALL_RED and increment dir modulo 4 on the same edge.
REQ-016 Any state with expired=0 and no watchdog trip SHALL hold.
REQ-017 Transition latency SHALL be exactly one clock: expired sampled high at edge N gives the new state after edge N.
REQ-018 lights SHALL be registered from next-state so they change on the same edge as state:
- ALL_RED: all four directions {1,0,0}
- green of d: direction d {0,0,1}, others {1,0,0}
- yellow of d: direction d {0,1,0}, others {1,0,0}
REQ-019 No encoding SHALL ever drive green or yellow on more than one direction.
REQ-020 cycle_done SHALL pulse for one cycle coincident with entering ALL_RED from direction-3 yellow (dir wraps 3->0).
REQ-021 A 6-bit dwell counter SHALL clear on every state change, increment each cycle the state holds, and saturate at 63.
REQ-022 When dwell == WDOG_LIMIT and expired=0, the next state SHALL be ALL_RED with dir unchanged (the interrupted direction is re-served), and fault SHALL set.
REQ-023 If expired=1 and the watchdog condition occur in the same cycle, the normal expired transition SHALL win and fault SHALL be unchanged.
REQ-024 An illegal state code SHALL force ALL_RED on the next edge and set fault.
REQ-025 fault SHALL remain 1 until rst; normal sequencing continues while fault=1.

Reset
REQ-026 On rst=1 at a clock edge, the block SHALL set: state=0000, dir=0, lights=12'b100_100_100_100, cycle_done=0, fault=0, dwell=0.
REQ-027 rst SHALL override expired and all in-progress phases, including assertion mid-green or mid-yellow.

Verification
REQ-028 Reset, then one expired pulse with congestion=0000 -> state=0001 next cycle; lights[2:0]=001, others 100.
REQ-029 Full rotation, congestion=0010, expired pulsed once per state -> states 0,1,3,0,5,6,0,7,9,0,10,12,0; cycle_done=1 only on the final entry to 0000.
REQ-030 In state 0001, expired held 0 for 40 cycles -> state=0000, fault=1; next expired -> 0001 (dir still 0).
REQ-031 Watchdog and expired coincide at dwell=40 in state 0001 -> state=0011, fault=0.
REQ-032 rst asserted in state 0110 with fault=1 -> next cycle state=0000, fault=0, lights all red, and the next expired gives 0001.
